// File: rtl/chan_bin_select_if.sv
// Stream bus carrying FFT bins (sample, sideband with bin index, frame marker)
// between channelizer stages.
interface chan_bin_select_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 24
) ();
    logic                   tvalid;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic                   tready;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/chan_bin_select.sv
// Forwards only the FFT bins enabled in a double-buffered per-bin mask and re-frames
// each frame so tlast lands on the last forwarded bin.
module chan_bin_select #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 24,
    parameter int BIN_WIDTH   = 11
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    chan_bin_select_if.slave     s_axis,
    chan_bin_select_if.master    m_axis,
    input  logic                 mask_wr_en,
    input  logic [BIN_WIDTH-1:0] mask_wr_addr,
    input  logic                 mask_wr_data,
    input  logic                 mask_commit,
    output logic                 commit_pending,
    output logic                 init_done,
    output logic [15:0]          empty_frame_cnt
);
    localparam int DEPTH = 2 ** BIN_WIDTH;

    typedef enum logic [1:0] {INIT, EMPTY, HOLD, FLUSH} state_t;

    state_t state;
    state_t state_nxt;

    // bit b of each entry belongs to bank b
    logic [1:0]           mask_mem [DEPTH];
    logic [BIN_WIDTH-1:0] init_addr;
    logic                 active_bank;
    logic                 at_boundary;
    logic                 swap_now;
    logic                 rd_bank;
    logic                 sel;
    logic [BIN_WIDTH-1:0] bin_idx;

    logic in_ready;
    logic take;
    logic out_free;

    logic load_pend;
    logic load_out;
    logic out_from_pend;
    logic out_last;
    logic cnt_inc;

    logic [DATA_WIDTH-1:0]  pend_data_p0;
    logic [TUSER_WIDTH-1:0] pend_user_p0;

    logic [DATA_WIDTH-1:0]  out_data_p1;
    logic [TUSER_WIDTH-1:0] out_user_p1;
    logic                   out_last_p1;
    logic                   vld_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A pending swap is applied in the same cycle its first new-frame beat is looked
    // up, so that beat already sees the new bank.
    assign swap_now = commit_pending & at_boundary & (state != INIT);
    assign rd_bank  = active_bank ^ swap_now;
    assign bin_idx  = s_axis.tuser[BIN_WIDTH-1:0];
    assign sel      = mask_mem[bin_idx][rd_bank];

    assign out_free = !vld_p1 | m_axis.tready;
    assign take     = s_axis.tvalid & in_ready;

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: begin
                if (&init_addr) begin
                    state_nxt = EMPTY;
                end
            end
            EMPTY: begin
                if (take && sel && !s_axis.tlast) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (take && s_axis.tlast) begin
                    state_nxt = sel ? FLUSH : EMPTY;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        in_ready      = out_free & ((state == EMPTY) | (state == HOLD));
        init_done     = (state != INIT);
        load_pend     = 1'b0;
        load_out      = 1'b0;
        out_from_pend = 1'b0;
        out_last      = 1'b0;
        cnt_inc       = 1'b0;
        case (state)
            FLUSH: begin
                if (out_free) begin
                    load_out      = 1'b1;
                    out_from_pend = 1'b1;
                    out_last      = 1'b1;
                end
            end
            EMPTY, HOLD: begin
                if (take) begin
                    if (sel) begin
                        // a selected tlast beat seen with nothing held goes straight out
                        load_pend = !(s_axis.tlast && (state == EMPTY));
                        if (state == HOLD) begin
                            load_out      = 1'b1;
                            out_from_pend = 1'b1;
                        end else if (s_axis.tlast) begin
                            load_out = 1'b1;
                            out_last = 1'b1;
                        end
                    end else if (s_axis.tlast) begin
                        if (state == HOLD) begin
                            load_out      = 1'b1;
                            out_from_pend = 1'b1;
                            out_last      = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign s_axis.tready = in_ready;

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mask_mem[init_addr] <= 2'b11;
        end else if (mask_wr_en) begin
            mask_mem[mask_wr_addr][~active_bank] <= mask_wr_data;
        end
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            init_addr       <= '0;
            active_bank     <= 1'b0;
            commit_pending  <= 1'b0;
            at_boundary     <= 1'b1;
            empty_frame_cnt <= '0;
            vld_p1          <= 1'b0;
        end else begin
            if (state == INIT) begin
                init_addr <= init_addr + 1'b1;
            end
            if (swap_now) begin
                active_bank <= ~active_bank;
            end
            if (mask_commit) begin
                commit_pending <= 1'b1;
            end else if (swap_now) begin
                commit_pending <= 1'b0;
            end
            if (take) begin
                at_boundary <= s_axis.tlast;
            end
            if (cnt_inc) begin
                empty_frame_cnt <= sat_inc(empty_frame_cnt);
            end
            if (load_out) begin
                vld_p1 <= 1'b1;
            end else if (m_axis.tready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // stage p0: pending sample, held until its successor or frame end is known
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            pend_data_p0 <= '0;
            pend_user_p0 <= '0;
        end else if (load_pend) begin
            pend_data_p0 <= s_axis.tdata;
            pend_user_p0 <= s_axis.tuser;
        end
    end

    // stage p1: output register, frozen while the consumer stalls
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            out_data_p1 <= '0;
            out_user_p1 <= '0;
            out_last_p1 <= 1'b0;
        end else if (load_out) begin
            out_data_p1 <= out_from_pend ? pend_data_p0 : s_axis.tdata;
            out_user_p1 <= out_from_pend ? pend_user_p0 : s_axis.tuser;
            out_last_p1 <= out_last;
        end
    end

    assign m_axis.tvalid = vld_p1;
    assign m_axis.tdata  = out_data_p1;
    assign m_axis.tuser  = out_user_p1;
    assign m_axis.tlast  = out_last_p1;
endmodule

// File: tb/tb_chan_bin_select.sv
// Bench for chan_bin_select: directed mask/frame table, mid-frame commit and reset
// sequences, and a randomized backpressured run against a scoreboard.
module tb_chan_bin_select;
    localparam int DW = 32;
    localparam int UW = 24;
    localparam int BW = 11;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } exp_t;

    typedef struct {
        logic [7:0] mask;
        bit         commit;
        bit         flush_chk;
        logic [7:0] exp_bins;
        int         exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic sync_reset;
    logic mask_wr_en;
    logic [BW-1:0] mask_wr_addr;
    logic mask_wr_data;
    logic mask_commit;
    logic commit_pending;
    logic init_done;
    logic [15:0] empty_frame_cnt;

    chan_bin_select_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_axis ();
    chan_bin_select_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_axis ();

    chan_bin_select #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .BIN_WIDTH(BW)) dut (
        .clk             (clk),
        .sync_reset      (sync_reset),
        .s_axis          (s_axis),
        .m_axis          (m_axis),
        .mask_wr_en      (mask_wr_en),
        .mask_wr_addr    (mask_wr_addr),
        .mask_wr_data    (mask_wr_data),
        .mask_commit     (mask_commit),
        .commit_pending  (commit_pending),
        .init_done       (init_done),
        .empty_frame_cnt (empty_frame_cnt)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t tbl[6];

    logic [DW-1:0] fr_data [32];
    logic [UW-1:0] fr_user [32];
    int            fr_bin  [32];
    int            fr_len;

    bit bank_m [2][16];
    bit active_m;
    int empty_m;
    bit bp_en;
    bit bp_force;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit          stall_prev = 1'b0;
        logic [56:0] prev = '0;
        logic [56:0] act;
        exp_t        e;
        forever begin
            @(negedge clk);
            act = {m_axis.tdata, m_axis.tuser, m_axis.tlast};
            if (sync_reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_hold", 64'({m_axis.tvalid, act}), 64'({1'b1, prev}));
                if (m_axis.tvalid && m_axis.tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h required no output", act);
                    end else begin
                        e = sb.pop_front();
                        check("out_beat", 64'(act), 64'({e.data, e.user, e.last}));
                    end
                end
                stall_prev = m_axis.tvalid && !m_axis.tready;
                prev = act;
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #2;
            m_axis.tready = bp_en ? 1'($urandom_range(0, 1)) : bp_force;
        end
    endtask

    task automatic make_frame(input int n, input bit rnd_bins);
        logic [12:0] hi;
        int b;
        fr_len = n;
        for (int i = 0; i < n; i++) begin
            b = rnd_bins ? int'($urandom_range(0, 15)) : i;
            hi = 13'($urandom);
            fr_bin[i]  = b;
            fr_user[i] = {hi, 11'(b)};
            fr_data[i] = $urandom;
        end
    endtask

    function automatic void push_exp(input int i, input bit last);
        exp_t e;
        e.data = fr_data[i];
        e.user = fr_user[i];
        e.last = last;
        sb.push_back(e);
    endfunction

    function automatic void push_model_frame();
        int last_sel = -1;
        for (int i = 0; i < fr_len; i++) if (bank_m[active_m][fr_bin[i]]) last_sel = i;
        if (last_sel < 0) empty_m++;
        for (int i = 0; i < fr_len; i++)
            if (bank_m[active_m][fr_bin[i]]) push_exp(i, i == last_sel);
    endfunction

    task automatic drive_beats(input int from, input int to);
        bit acc;
        int n;
        for (int i = from; i <= to; i++) begin
            s_axis.tdata  = fr_data[i];
            s_axis.tuser  = fr_user[i];
            s_axis.tlast  = (i == fr_len - 1);
            s_axis.tvalid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc) begin
                @(negedge clk);
                if (s_axis.tready) begin
                    acc = 1'b1;
                end else if (++n > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: beat %0d never accepted (s_axis_tready stuck 0)", i);
                    acc = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic write_mask(input int n, input logic [15:0] m);
        int sh = active_m ? 0 : 1;
        for (int b = 0; b < n; b++) begin
            mask_wr_en   = 1'b1;
            mask_wr_addr = 11'(b);
            mask_wr_data = m[b];
            @(posedge clk);
            #1;
            bank_m[sh][b] = m[b];
        end
        mask_wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        mask_commit = 1'b1;
        @(posedge clk);
        #1;
        mask_commit = 1'b0;
    endtask

    task automatic commit_and_check();
        pulse_commit();
        @(negedge clk);
        check("commit_pending_set", 64'(commit_pending), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("commit_pending_clr", 64'(commit_pending), 64'd0);
        @(posedge clk);
        #1;
        active_m = ~active_m;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        repeat (2047) @(posedge clk);
        @(negedge clk);
        check("init_done_early", 64'(init_done), 64'd0);
        check("tready_in_init", 64'(s_axis.tready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("init_done_2048", 64'(init_done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        active_m = 1'b0;
        for (int k = 0; k < 2; k++) for (int b = 0; b < 16; b++) bank_m[k][b] = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst_m_tdata", 64'({m_axis.tdata, m_axis.tlast}), 64'd0);
        check("rst_s_tready", 64'(s_axis.tready), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_commit_pending", 64'(commit_pending), 64'd0);
        check("rst_empty_cnt", 64'(empty_frame_cnt), 64'd0);
    endtask

    task automatic mid_frame_commit();
        write_mask(8, 16'h0001);
        make_frame(8, 1'b0);
        push_exp(2, 1'b0);
        push_exp(5, 1'b1);
        drive_beats(0, 3);
        pulse_commit();
        @(negedge clk);
        check("midframe_pending", 64'(commit_pending), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midframe_no_swap", 64'(commit_pending), 64'd1);
        @(posedge clk);
        #1;
        drive_beats(4, 7);
        wait_drain();
        @(negedge clk);
        check("frame_end_swap", 64'(commit_pending), 64'd0);
        @(posedge clk);
        #1;
        active_m = ~active_m;
        make_frame(8, 1'b0);
        push_exp(0, 1'b1);
        drive_beats(0, 7);
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 7};
        tbl[1] = '{8'h24, 1'b1, 1'b0, 8'h24, 5};
        tbl[2] = '{8'hC0, 1'b1, 1'b1, 8'hC0, 7};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 0};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 0};
        tbl[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 0};

        sync_reset    = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tuser  = '0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
        mask_wr_en    = 1'b0;
        mask_wr_addr  = '0;
        mask_wr_data  = 1'b0;
        mask_commit   = 1'b0;
        bp_en         = 1'b0;
        bp_force      = 1'b1;
        empty_m       = 0;
        model_reset();

        fork
            monitor();
            ready_driver();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        wait_init();

        for (int k = 0; k < 6; k++) begin
            if (k == 2) mid_frame_commit();
            if (tbl[k].commit) begin
                write_mask(8, {8'h00, tbl[k].mask});
                commit_and_check();
            end
            make_frame(8, 1'b0);
            for (int i = 0; i < 8; i++)
                if (tbl[k].exp_bins[i]) push_exp(i, i == tbl[k].exp_last);
            if (tbl[k].exp_bins == 8'h00) empty_m++;
            drive_beats(0, 7);
            if (tbl[k].flush_chk) begin
                @(negedge clk);
                check("flush_tready_low", 64'(s_axis.tready), 64'd0);
                @(negedge clk);
                check("flush_tready_back", 64'(s_axis.tready), 64'd1);
                @(posedge clk);
                #1;
            end
            wait_drain();
        end
        check("empty_cnt_directed", 64'(empty_frame_cnt), 64'd3);

        bp_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            if (f % 4 == 0) begin
                write_mask(16, 16'($urandom));
                commit_and_check();
            end
            make_frame(int'($urandom_range(1, 16)), 1'b1);
            push_model_frame();
            drive_beats(0, fr_len - 1);
        end
        bp_en = 1'b0;
        bp_force = 1'b1;
        wait_drain();
        check("empty_cnt_random", 64'(empty_frame_cnt), 64'(empty_m));

        bp_force = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        make_frame(4, 1'b0);
        drive_beats(0, 1);
        sync_reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        model_reset();
        bp_force = 1'b1;
        wait_init();
        make_frame(4, 1'b0);
        push_model_frame();
        drive_beats(0, 3);
        wait_drain();
        check("empty_cnt_after_reset", 64'(empty_frame_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
